// File: rtl/id_stage_ctrl.sv
// rtl/id_stage_ctrl.sv - rv32i decode-stage controller: ImmGen drive, ID/EX register and skid entry
// Optional load-use bubble insertion is compiled in when IDCTRL_LOADUSE_EN is defined.
module id_stage_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [24:0]     imm_instr,
    output logic [2:0]      imm_src,
    input  logic [XLEN-1:0] imm_ext,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic            ex_illegal,
    input  logic            flush
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } stateT;

    typedef struct packed {
        logic [2:0] immSrc;
        logic       immZero;
        logic       illegal;
    } decodeT;

    function automatic decodeT decodeOp(input logic [6:0] opcode);
        decodeT d;
        d = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: d.immSrc = IMM_I;
            OP_STORE:                 d.immSrc = IMM_S;
            OP_BRANCH:                d.immSrc = IMM_B;
            OP_LUI, OP_AUIPC:         d.immSrc = IMM_U;
            OP_JAL:                   d.immSrc = IMM_J;
            OP_REG:                   d.immZero = 1'b1;
            default: begin
                d.immZero = 1'b1;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    stateT           state;
    logic            skidValid;
    logic [31:0]     skidInstr;
    logic [XLEN-1:0] skidPc;

    logic [31:0]     headInstr;
    logic [XLEN-1:0] headPc;
    logic            headValid;
    logic            headAvail;
    logic            inFire;
    logic            outFire;
    logic            slotFree;
    logic            hazard;
    logic            loadHead;
    decodeT          headDec;
    logic [XLEN-1:0] headImm;

    // The skid entry is always older than the fetch word, so it is the head whenever valid.
    assign headInstr = skidValid ? skidInstr : if_instr;
    assign headPc    = skidValid ? skidPc : if_pc;
    assign headValid = skidValid | if_valid;
    assign if_ready  = ~skidValid;
    assign inFire    = if_valid & if_ready;
    assign outFire   = ex_valid & ex_ready;
    assign headAvail = skidValid | inFire;
    assign slotFree  = ~ex_valid | outFire;
    assign headDec   = decodeOp(headInstr[6:0]);
    assign headImm   = headDec.immZero ? '0 : imm_ext;
    assign imm_instr = headValid ? headInstr[31:7] : '0;
    assign imm_src   = headValid ? headDec.immSrc : '0;

`ifdef IDCTRL_LOADUSE_EN
    logic       bubble;
    logic [4:0] exRd;
    logic       headRs1;
    logic       headRs2;
    logic       headUsesRd;

    always_comb begin
        headRs1 = 1'b0;
        headRs2 = 1'b0;
        case (headInstr[6:0])
            OP_REG, OP_STORE, OP_BRANCH: begin
                headRs1 = 1'b1;
                headRs2 = 1'b1;
            end
            OP_LOAD, OP_IMM, OP_JALR: headRs1 = 1'b1;
            default: ;
        endcase
    end

    assign exRd       = ex_instr[11:7];
    assign headUsesRd = (headRs1 && headInstr[19:15] == exRd) ||
                        (headRs2 && headInstr[24:20] == exRd);
    assign hazard     = outFire && !bubble && ex_instr[6:0] == OP_LOAD &&
                        exRd != 5'd0 && headAvail && headUsesRd;
`else
    assign hazard = 1'b0;
`endif

    assign loadHead = slotFree & headAvail & ~hazard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            skidValid  <= 1'b0;
            skidInstr  <= '0;
            skidPc     <= '0;
            ex_valid   <= 1'b0;
            ex_instr   <= '0;
            ex_pc      <= '0;
            ex_imm     <= '0;
            ex_illegal <= 1'b0;
`ifdef IDCTRL_LOADUSE_EN
            bubble     <= 1'b0;
`endif
        end else if (flush) begin
            state     <= EMPTY;
            skidValid <= 1'b0;
            ex_valid  <= 1'b0;
`ifdef IDCTRL_LOADUSE_EN
            bubble    <= 1'b0;
`endif
        end else begin
            // State counts held entries; during a bubble the lone entry sits in skid.
            case (state)
                EMPTY: if (inFire) state <= ONE;
                ONE: begin
                    if (outFire && !inFire)
                        state <= EMPTY;
                    else if (inFire && !outFire)
                        state <= TWO;
                end
                TWO: if (outFire) state <= ONE;
                default: state <= EMPTY;
            endcase

            if (loadHead) begin
                ex_valid   <= 1'b1;
                ex_instr   <= headInstr;
                ex_pc      <= headPc;
                ex_imm     <= headImm;
                ex_illegal <= headDec.illegal;
            end else if (outFire) begin
                ex_valid <= 1'b0;
            end

            if (loadHead) begin
                skidValid <= 1'b0;
            end else if (inFire) begin
                skidValid <= 1'b1;
                skidInstr <= if_instr;
                skidPc    <= if_pc;
            end
`ifdef IDCTRL_LOADUSE_EN
            bubble <= hazard;
`endif
        end
    end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb/tb_id_stage_ctrl.sv - self-checking bench for id_stage_ctrl with an ImmGen model and scoreboard
module tb_id_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [24:0] imm_instr;
    logic [2:0]  imm_src;
    logic [31:0] imm_ext;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic        ex_illegal;
    logic        flush;

    int checks = 0;
    int errors = 0;
    logic [31:0] pcCnt;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ill;
    } expT;
    expT sbq[$];

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] imm;
        logic        ill;
    } vecT;
    vecT vec[11];

    localparam logic [31:0] I_ADDI  = 32'hFFF00093;
    localparam logic [31:0] I_ADDI5 = 32'h00500093;
    localparam logic [31:0] I_SW    = 32'h00112223;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_ADD   = 32'h00528333;

    id_stage_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .imm_instr  (imm_instr),
        .imm_src    (imm_src),
        .imm_ext    (imm_ext),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_instr   (ex_instr),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .ex_illegal (ex_illegal),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] immOf(input logic [2:0] src, input logic [31:0] i);
        case (src)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {i[31:12], 12'b0};
            3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] refImm(input logic [31:0] i);
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: return immOf(3'd0, i);
            7'b0100011:                         return immOf(3'd1, i);
            7'b1100011:                         return immOf(3'd2, i);
            7'b0110111, 7'b0010111:             return immOf(3'd3, i);
            7'b1101111:                         return immOf(3'd4, i);
            default:                            return 32'h0;
        endcase
    endfunction

    function automatic logic refIll(input logic [31:0] i);
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // External ImmGen: combinational from the controller's imm_instr/imm_src.
    always_comb begin
        imm_ext = immOf(imm_src, {imm_instr, 7'b0});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        expT e;
        e.instr = instr;
        e.pc    = pc;
        e.imm   = refImm(instr);
        e.ill   = refIll(instr);
        sbq.push_back(e);
    endtask

    // Called at posedge+1; leaves if_valid high so successive calls stream back-to-back.
    task automatic send(input logic [31:0] instr);
        int n;
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pcCnt;
        n = 0;
        @(negedge clk);
        while (!if_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!if_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: if_ready got 0 expected 1 for instr %h", instr);
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            push(instr, pcCnt);
        end
        pcCnt = pcCnt + 32'd4;
    endtask

    always @(negedge clk) begin : monitor
        expT e;
        if (rst_n && ex_valid && ex_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: issued %h expected no issue", ex_instr);
            end else begin
                e = sbq.pop_front();
                check("sb_instr", ex_instr, e.instr);
                check("sb_pc", ex_pc, e.pc);
                check("sb_imm", ex_imm, e.imm);
                check("sb_illegal", 32'(ex_illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0};
        vec[1]  = '{32'h00112223, 3'd1, 32'h00000004, 1'b0};
        vec[2]  = '{32'h00000000, 3'd0, 32'h00000000, 1'b1};
        vec[3]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0};
        vec[4]  = '{32'h123450B7, 3'd3, 32'h12345000, 1'b0};
        vec[5]  = '{32'h008000EF, 3'd4, 32'h00000008, 1'b0};
        vec[6]  = '{32'h00528333, 3'd0, 32'h00000000, 1'b0};
        vec[7]  = '{32'h00001117, 3'd3, 32'h00001000, 1'b0};
        vec[8]  = '{32'hFFC08067, 3'd0, 32'hFFFFFFFC, 1'b0};
        vec[9]  = '{32'hFFFFFFFF, 3'd0, 32'h00000000, 1'b1};
        vec[10] = '{32'h0000A283, 3'd0, 32'h00000000, 1'b0};

        // Reset held with a valid fetch word present.
        pcCnt    = 32'h100;
        rst_n    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = I_ADDI;
        if_pc    = pcCnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd1);
        check("rst_ex_imm", ex_imm, 32'h0);
        check("rst_ex_instr", ex_instr, 32'h0);
        check("rst_ex_illegal", 32'(ex_illegal), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_if_ready", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;
        push(I_ADDI, pcCnt);
        pcCnt    = pcCnt + 32'd4;
        if_valid = 1'b0;
        @(negedge clk);
        check("first_ex_valid", 32'(ex_valid), 32'd1);
        check("first_ex_instr", ex_instr, I_ADDI);
        @(posedge clk);
        #1;

        // Decode table: one instruction at a time with EX always ready.
        for (int i = 0; i < 11; i++) begin
            if_valid = 1'b1;
            if_instr = vec[i].instr;
            if_pc    = pcCnt;
            @(negedge clk);
            check($sformatf("v%0d_imm_src", i), 32'(imm_src), 32'(vec[i].src));
            check($sformatf("v%0d_if_ready", i), 32'(if_ready), 32'd1);
            @(posedge clk);
            #1;
            push(vec[i].instr, pcCnt);
            pcCnt    = pcCnt + 32'd4;
            if_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'd1);
            check($sformatf("v%0d_ex_instr", i), ex_instr, vec[i].instr);
            check($sformatf("v%0d_ex_imm", i), ex_imm, vec[i].imm);
            check($sformatf("v%0d_ex_illegal", i), 32'(ex_illegal), 32'(vec[i].ill));
            check($sformatf("v%0d_idle_imm_instr", i), 32'(imm_instr), 32'd0);
            @(posedge clk);
            #1;
        end

        // Back-pressure: A then B with EX stalled, then drain in order.
        ex_ready = 1'b0;
        send(I_ADDI5);
        send(I_SW);
        if_valid = 1'b0;
        if_instr = I_LUI;
        @(negedge clk);
        check("bp_if_ready_two", 32'(if_ready), 32'd0);
        check("bp_ex_instr_a", ex_instr, I_ADDI5);
        check("bp_head_skid_src", 32'(imm_src), 32'd1);
        check("bp_head_skid_instr", 32'(imm_instr), 32'(I_SW >> 7));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_hold_instr", ex_instr, I_ADDI5);
        check("bp_hold_imm", ex_imm, 32'h5);
        check("bp_hold_valid", 32'(ex_valid), 32'd1);
        @(posedge clk);
        #1;
        ex_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ex_instr_b", ex_instr, I_SW);
        check("bp_if_ready_back", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_drained", 32'(ex_valid), 32'd0);
        @(posedge clk);
        #1;

        // Load-use: LW x5 immediately followed by ADD x6,x5,x5.
        if_valid = 1'b1;
        if_instr = I_LW;
        if_pc    = pcCnt;
        @(negedge clk);
        @(posedge clk);
        #1;
        push(I_LW, pcCnt);
        pcCnt    = pcCnt + 32'd4;
        if_instr = I_ADD;
        if_pc    = pcCnt;
        @(negedge clk);
        check("lu_ex_lw", ex_instr, I_LW);
        check("lu_if_ready", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;
        push(I_ADD, pcCnt);
        pcCnt    = pcCnt + 32'd4;
        if_valid = 1'b0;
        @(negedge clk);
`ifdef IDCTRL_LOADUSE_EN
        check("lu_bubble", 32'(ex_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
`endif
        check("lu_add_valid", 32'(ex_valid), 32'd1);
        check("lu_add_instr", ex_instr, I_ADD);
        @(posedge clk);
        #1;

        // Flush in state TWO: neither held entry may ever issue.
        ex_ready = 1'b0;
        send(I_ADDI5);
        send(I_SW);
        if_instr = I_LUI;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        if_valid = 1'b0;
        sbq.delete();
        @(negedge clk);
        check("fl_ex_valid", 32'(ex_valid), 32'd0);
        check("fl_if_ready", 32'(if_ready), 32'd1);
        check("fl_imm_src_idle", 32'(imm_src), 32'd0);
        ex_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("fl_no_issue", 32'(ex_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Flush wins over an accept in the same cycle.
        if_valid = 1'b1;
        if_instr = I_ADDI;
        if_pc    = pcCnt;
        flush    = 1'b1;
        @(negedge clk);
        check("flp_if_ready", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        if_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("flp_discarded", 32'(ex_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random back-pressure stream; the scoreboard checks order and contents.
        fork
            begin
                for (int k = 0; k < 24; k++)
                    send(vec[$urandom_range(0, 10)].instr);
                if_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    @(posedge clk);
                    #1;
                    ex_ready = ($urandom_range(0, 3) != 0);
                end
                ex_ready = 1'b1;
            end
        join
        ex_ready = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("stream_drained", 32'(sbq.size()), 32'd0);
        @(negedge clk);
        check("stream_idle", 32'(ex_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
